// File: rtl/audio_pkg.sv
// Shared audio constants and types, used by both the DAC transmitter and the ADC receiver.
package audio_pkg;

    localparam int AUDIO_SAMPLE_WIDTH = 24;
    localparam int AUDIO_FRAME_BITS   = 64;
    localparam int AUDIO_SLOT_BITS    = 32;

    typedef logic signed [AUDIO_SAMPLE_WIDTH-1:0] audio_sample_t;

    // True when a frame bit position falls inside the inclusive window [lo, hi].
    function automatic logic in_window(input int unsigned pos, input int unsigned lo,
                                       input int unsigned hi);
        return (pos >= lo) && (pos <= hi);
    endfunction

endpackage

// File: rtl/audio_bclk_gen.sv
// Bit clock generator: divides clk by 2*BCLK_DIV and flags the cycle on which BCLK falls.
module audio_bclk_gen #(
    parameter int BCLK_DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    output logic aud_bclk,
    output logic bclk_fall
);

    localparam int CNT_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(BCLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt_reg;
    logic             bclk_reg;
    logic             terminal;

    assign terminal = (div_cnt_reg == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_reg <= '0;
            bclk_reg    <= 1'b0;
        end else if (terminal) begin
            div_cnt_reg <= '0;
            bclk_reg    <= ~bclk_reg;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    // Combinational so that data updates land on the same edge that drops BCLK.
    assign bclk_fall = terminal && bclk_reg;
    assign aud_bclk  = bclk_reg;

endmodule

// File: rtl/audio_dac_tx.sv
// Master-mode I2S transmitter for 24-bit stereo pairs with a one-entry holding register.
// Optional underrun counter port enabled by defining AUDIO_TX_UNDERRUN_CNT_EN.
module audio_dac_tx
    import audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH,
    parameter int BCLK_DIV     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SAMPLE_WIDTH-1:0] sample_left,
    input  logic [SAMPLE_WIDTH-1:0] sample_right,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic                    aud_bclk,
    output logic                    aud_daclrck,
    output logic                    aud_dacdat
`ifdef AUDIO_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]             underrun_count
`endif
);

    localparam int CNT_W = $clog2(AUDIO_FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(AUDIO_FRAME_BITS - 1);
    localparam int unsigned LEFT_LO  = 1;
    localparam int unsigned LEFT_HI  = SAMPLE_WIDTH;
    localparam int unsigned RIGHT_LO = AUDIO_SLOT_BITS + 1;
    localparam int unsigned RIGHT_HI = AUDIO_SLOT_BITS + SAMPLE_WIDTH;

    logic                    bclk_fall;
    logic [CNT_W-1:0]        bit_cnt_reg;
    logic [CNT_W-1:0]        bit_cnt_next;
    logic [SAMPLE_WIDTH-1:0] hold_left_reg, hold_right_reg;
    logic [SAMPLE_WIDTH-1:0] left_sr_reg, right_sr_reg;
    logic                    hold_full_reg;
    logic                    lrck_reg, dat_reg;
    logic                    accept, frame_load, left_bit, right_bit;

    audio_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .aud_bclk  (aud_bclk),
        .bclk_fall (bclk_fall)
    );

    assign accept       = sample_valid && !hold_full_reg;
    assign frame_load   = bclk_fall && (bit_cnt_reg == LAST_BIT);
    assign bit_cnt_next = bit_cnt_reg + 1'b1;
    assign left_bit     = in_window(32'(bit_cnt_next), LEFT_LO, LEFT_HI);
    assign right_bit    = in_window(32'(bit_cnt_next), RIGHT_LO, RIGHT_HI);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_reg    <= '0;
            hold_left_reg  <= '0;
            hold_right_reg <= '0;
            left_sr_reg    <= '0;
            right_sr_reg   <= '0;
            hold_full_reg  <= 1'b0;
            lrck_reg       <= 1'b0;
            dat_reg        <= 1'b0;
        end else begin
            if (bclk_fall) begin
                bit_cnt_reg <= bit_cnt_next;
                lrck_reg    <= bit_cnt_next[CNT_W-1];
                if (frame_load) begin
                    dat_reg <= 1'b0;
                    // An empty holding register here is an underrun: play a mute frame.
                    if (hold_full_reg) begin
                        left_sr_reg   <= hold_left_reg;
                        right_sr_reg  <= hold_right_reg;
                        hold_full_reg <= 1'b0;
                    end else begin
                        left_sr_reg  <= '0;
                        right_sr_reg <= '0;
                    end
                end else if (left_bit) begin
                    dat_reg     <= left_sr_reg[SAMPLE_WIDTH-1];
                    left_sr_reg <= left_sr_reg << 1;
                end else if (right_bit) begin
                    dat_reg      <= right_sr_reg[SAMPLE_WIDTH-1];
                    right_sr_reg <= right_sr_reg << 1;
                end else begin
                    dat_reg <= 1'b0;
                end
            end
            // Accept only happens while empty, so it never collides with a draining load.
            if (accept) begin
                hold_left_reg  <= sample_left;
                hold_right_reg <= sample_right;
                hold_full_reg  <= 1'b1;
            end
        end
    end

`ifdef AUDIO_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            underrun_cnt_reg <= '0;
        end else if (frame_load && !hold_full_reg && (underrun_cnt_reg != 16'hFFFF)) begin
            underrun_cnt_reg <= underrun_cnt_reg + 16'd1;
        end
    end

    assign underrun_count = underrun_cnt_reg;
`endif

    assign sample_ready = !hold_full_reg;
    assign aud_daclrck  = lrck_reg;
    assign aud_dacdat   = dat_reg;

endmodule

// File: tb/tb_audio_dac_tx.sv
// Scoreboard bench for audio_dac_tx: expected frames are queued at accept time and compared per frame.
module tb_audio_dac_tx;

    localparam int SW         = 24;
    localparam int DIV        = 8;
    localparam int FRAME_CLKS = 128 * DIV;
    localparam logic [63:0] LR_EXP = 64'h0000_0000_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [SW-1:0] sample_left = '0;
    logic [SW-1:0] sample_right = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic          aud_bclk, aud_daclrck, aud_dacdat;
`ifdef AUDIO_TX_UNDERRUN_CNT_EN
    logic [15:0]   underrun_count;
`endif

    audio_dac_tx #(.SAMPLE_WIDTH(SW), .BCLK_DIV(DIV)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .aud_bclk     (aud_bclk),
        .aud_daclrck  (aud_daclrck),
        .aud_dacdat   (aud_dacdat)
`ifdef AUDIO_TX_UNDERRUN_CNT_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    always #5 clk = ~clk;

    // Count of rising clk edges since reset release; frame loads fall on multiples of FRAME_CLKS.
    int cyc = 0;
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int          frame;
        logic [63:0] bits;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] frame_bits(input logic [SW-1:0] l, input logic [SW-1:0] r);
        logic [63:0] f;
        f = '0;
        for (int i = 0; i < SW; i++) begin
            f[63-(1+i)]  = l[SW-1-i];
            f[63-(33+i)] = r[SW-1-i];
        end
        return f;
    endfunction

    // Monitor: capture one bit per BCLK rising edge, compare each completed 64-bit frame.
    int          bit_idx = 0;
    int          frame_num = 0;
    logic        prev_bclk = 1'b0;
    logic [63:0] cur_dat = '0;
    logic [63:0] cur_lr = '0;
    initial begin
        logic [63:0] exp_bits;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bit_idx   = 0;
                frame_num = 0;
                prev_bclk = 1'b0;
                cur_dat   = '0;
                cur_lr    = '0;
            end else begin
                if (aud_bclk && !prev_bclk) begin
                    cur_dat[63-bit_idx] = aud_dacdat;
                    cur_lr[63-bit_idx]  = aud_daclrck;
                    bit_idx++;
                    if (bit_idx == 64) begin
                        exp_bits = '0;
                        if (sb.size() > 0 && sb[0].frame == frame_num) begin
                            exp_bits = sb[0].bits;
                            void'(sb.pop_front());
                        end
                        $display("frame %0d: dat=%h lrck=%h expected dat=%h",
                                 frame_num, cur_dat, cur_lr, exp_bits);
                        check_eq("frame_dat", cur_dat, exp_bits);
                        check_eq("frame_lrck", cur_lr, LR_EXP);
                        frame_num++;
                        bit_idx = 0;
                    end
                end
                prev_bclk = aud_bclk;
            end
        end
    end

    task automatic push(input logic [SW-1:0] l, input logic [SW-1:0] r,
                        output int tgt, output int acc_edge);
        int waited;
        waited = 0;
        @(negedge clk);
        sample_left  = l;
        sample_right = r;
        sample_valid = 1'b1;
        while (!sample_ready && waited < 4 * FRAME_CLKS) begin
            @(negedge clk);
            waited++;
        end
        if (!sample_ready) begin
            check_eq("push_ready_timeout", 64'(sample_ready), 64'd1);
            sample_valid = 1'b0;
            tgt = -1;
            acc_edge = -1;
            return;
        end
        acc_edge = cyc + 1;
        tgt = acc_edge / FRAME_CLKS + 1;
        sb.push_back('{tgt, frame_bits(l, r)});
        $display("push L=%h R=%h accept_edge=%0d frame=%0d", l, r, acc_edge, tgt);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        sample_valid = 1'b0;
        sample_left  = SW'($urandom);
        sample_right = SW'($urandom);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frame_done(input int f);
        while (cyc < (f + 1) * FRAME_CLKS + 2 * DIV) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_bclk"},  64'(aud_bclk),     64'd0);
        check_eq({tag, "_lrck"},  64'(aud_daclrck),  64'd0);
        check_eq({tag, "_dat"},   64'(aud_dacdat),   64'd0);
        check_eq({tag, "_ready"}, 64'(sample_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, a1, t2, a2, t4, t5, a5, guard;
        // Reset state
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Idle frames: data stays zero, ready stays high
        for (int k = 0; k < 12; k++) begin
            repeat (256) @(negedge clk);
            check_eq("idle_ready", 64'(sample_ready), 64'd1);
        end

        // Single pair followed by a mute frame
        push(24'hA5A5A5, 24'h5A5A5A, t1, a1);
        idle(4);
        wait_frame_done(t1 + 1);

        // Back-to-back pairs: second is held until the first pair's load
        push(24'h800001, 24'h7FFFFF, t1, a1);
        @(negedge clk);
        check_eq("held_ready_low", 64'(sample_ready), 64'd0);
        push(24'h123456, 24'hFEDCBA, t2, a2);
        check_eq("second_frame", 64'(t2), 64'(t1 + 1));
        check_eq("ready_after_load", 64'(a2), 64'(t1 * FRAME_CLKS + 1));
        idle(4);
        wait_frame_done(t2 + 1);

        // Accept exactly on the load cycle: that frame is an underrun
        guard = 0;
        while (((cyc + 1) % FRAME_CLKS) != 0 && guard < 2 * FRAME_CLKS) begin
            @(negedge clk);
            guard++;
        end
        check_eq("load_cycle_ready", 64'(sample_ready), 64'd1);
        begin
`ifdef AUDIO_TX_UNDERRUN_CNT_EN
            logic [15:0] ucnt_before;
            ucnt_before = underrun_count;
`endif
            sample_left  = 24'h3C3C3C;
            sample_right = 24'hC3C3C3;
            sample_valid = 1'b1;
            t4 = (cyc + 1) / FRAME_CLKS + 1;
            sb.push_back('{t4, frame_bits(24'h3C3C3C, 24'hC3C3C3)});
            $display("push on load edge %0d frame=%0d", cyc + 1, t4);
            @(posedge clk);
            idle(0);
`ifdef AUDIO_TX_UNDERRUN_CNT_EN
            check_eq("underrun_inc", 64'(underrun_count), 64'(ucnt_before + 16'd1));
`endif
        end
        wait_frame_done(t4);

        // Mid-frame reset discards the frame in flight and the held pair
        push(24'hFFFFFF, 24'hFFFFFF, t5, a5);
        push(24'h0F0F0F, 24'hF0F0F0, t2, a2);
        idle(0);
        while (cyc < t5 * FRAME_CLKS + 165) @(negedge clk);
        check_eq("mid_left_bit", 64'(aud_dacdat), 64'd1);
        check_eq("mid_left_lrck", 64'(aud_daclrck), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_frame_done(1);

`ifdef AUDIO_TX_UNDERRUN_CNT_EN
        // Saturation of the underrun counter
        force dut.underrun_cnt_reg = 16'hFFFE;
        @(negedge clk);
        release dut.underrun_cnt_reg;
        repeat (3 * FRAME_CLKS + 4) @(negedge clk);
        check_eq("underrun_sat", 64'(underrun_count), 64'hFFFF);
`endif

        check_eq("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
